jt51_lfo: RTL and testbench

- Low-frequency oscillator for the OPM core.
- Produces the per-sample amplitude-modulation word `am`, consumed by the envelope stage's AM/TL summer, and the signed phase-modulation word `pm`, consumed by the phase generator.
- Advances once per 32-slot sample (`zero`) and offers four waveforms.
- Depth scaling uses a small sequential multiplier that completes well inside one sample.

---
 rtl/jt51_lfo_pkg.sv | 23 ++
 rtl/jt51_lfo_mul.sv | 78 +++++++
 rtl/jt51_lfo.sv | 172 +++++++++++++++++
 tb/tb_jt51_lfo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_lfo_pkg.sv
// Shared encodings and constants for the OPM low-frequency oscillator.
package jt51_lfo_pkg;

    localparam logic [1:0] W_SAW   = 2'd0;
    localparam logic [1:0] W_SQR   = 2'd1;
    localparam logic [1:0] W_TRI   = 2'd2;
    localparam logic [1:0] W_NOISE = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } lfo_state_e;

    // Bits 16 and 13 of the register, i.e. taps 17 and 14.
    localparam logic [16:0] LFSR_TAPS = 17'h12000;
    localparam int          MUL_STEPS = 7;

    function automatic logic lfsr_feedback(input logic [16:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/jt51_lfo_mul.sv
// Sequential 8x7 shift-add multiplier; one multiplier bit per cen-cycle.
// SIGNED_A selects two's complement interpretation of the 8-bit operand.
module jt51_lfo_mul #(
    parameter bit SIGNED_A = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  a,
    input  logic [6:0]  b,
    output logic [14:0] prod,
    output logic        done
);
    import jt51_lfo_pkg::*;

    localparam logic [2:0] LAST_STEP = 3'(MUL_STEPS - 1);

    logic [14:0] mcand_q, mcand_d;
    logic [6:0]  mplier_q, mplier_d;
    logic [14:0] prod_q, prod_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [14:0] a_ext;

    assign a_ext = SIGNED_A ? {{7{a[7]}}, a} : {7'b0, a};

    // done marks the cen-cycle whose edge performs the final step.
    assign done = cen & busy_q & ~start & ~abort & (cnt_q == LAST_STEP);
    assign prod = prod_q;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (cen) begin
            if (abort) begin
                busy_d = 1'b0;
            end else if (start) begin
                mcand_d  = a_ext;
                mplier_d = b;
                prod_d   = '0;
                cnt_d    = '0;
                busy_d   = 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == LAST_STEP) begin
                    busy_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/jt51_lfo.sv
// OPM LFO: phase accumulator, noise LFSR, four waveforms and depth scaling.
// Define JT51_LFO_PHASE_OUT_EN to expose the accumulator phase on phase_o.
module jt51_lfo #(
    parameter int          ACC_W = 20,
    parameter logic [16:0] SEED  = 17'h1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    input  logic       lfo_rst,
    input  logic [7:0] lfo_freq,
    input  logic [1:0] lfo_w,
    input  logic [6:0] lfo_amd,
    input  logic [6:0] lfo_pmd,
    output logic [6:0] am,
`ifdef JT51_LFO_PHASE_OUT_EN
    output logic [7:0] pm,
    output logic [7:0] phase_o
`else
    output logic [7:0] pm
`endif
);
    import jt51_lfo_pkg::*;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_step;
    logic [ACC_W:0]   acc_sum;
    logic             acc_wrap;
    logic [7:0]       phase;
    logic [16:0]      lfsr_q, lfsr_d;
    logic [7:0]       noise_q, noise_d;
    lfo_state_e       state_q, state_d;
    logic [6:0]       am_q, am_d;
    logic [7:0]       pm_q, pm_d;
    logic [7:0]       ua, sp, tri_val;
    logic             mul_start, mul_abort;
    logic [14:0]      am_prod, pm_prod;
    logic             am_done, pm_done;
    logic             unused_mul;

    assign acc_step = ACC_W'({1'b1, lfo_freq[3:0]}) << lfo_freq[7:4];
    assign acc_sum  = {1'b0, acc_q} + {1'b0, acc_step};
    assign acc_wrap = acc_sum[ACC_W];
    assign phase    = acc_q[ACC_W-1 -: 8];

    assign mul_abort = cen & lfo_rst;
    assign mul_start = cen & ~lfo_rst & zero;

    always_comb begin
        acc_d   = acc_q;
        lfsr_d  = lfsr_q;
        noise_d = noise_q;
        if (cen) begin
            if (lfo_rst) begin
                acc_d = '0;
            end else if (zero) begin
                acc_d  = acc_sum[ACC_W-1:0];
                lfsr_d = {lfsr_q[15:0], lfsr_feedback(lfsr_q)};
                if (acc_wrap) begin
                    noise_d = lfsr_q[7:0];
                end
            end
        end
    end

    // Raw waveform operands; only meaningful on the tick, where the multipliers latch them.
    always_comb begin
        tri_val = phase[7] ? (8'd255 - {phase[6:0], 1'b0}) : {phase[6:0], 1'b0};
        ua      = 8'd255 - phase;
        sp      = phase - 8'd128;
        case (lfo_w)
            W_SAW: begin
                ua = 8'd255 - phase;
                sp = phase - 8'd128;
            end
            W_SQR: begin
                ua = phase[7] ? 8'd0 : 8'd255;
                sp = phase[7] ? 8'h80 : 8'h7F;
            end
            W_TRI: begin
                ua = tri_val;
                sp = tri_val - 8'd128;
            end
            W_NOISE: begin
                ua = noise_q;
                sp = noise_q - 8'd128;
            end
            default: ;
        endcase
    end

    jt51_lfo_mul #(.SIGNED_A(1'b0)) u_am_mul (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .start (mul_start),
        .abort (mul_abort),
        .a     (ua),
        .b     (lfo_amd),
        .prod  (am_prod),
        .done  (am_done)
    );

    jt51_lfo_mul #(.SIGNED_A(1'b1)) u_pm_mul (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .start (mul_start),
        .abort (mul_abort),
        .a     (sp),
        .b     (lfo_pmd),
        .prod  (pm_prod),
        .done  (pm_done)
    );

    // Both multipliers run in lockstep, so the AM unit's done paces the FSM.
    assign unused_mul = &{1'b0, am_prod[7:0], pm_prod[6:0], pm_done};

    always_comb begin
        state_d = state_q;
        am_d    = am_q;
        pm_d    = pm_q;
        if (cen) begin
            if (lfo_rst) begin
                state_d = IDLE;
            end else if (zero) begin
                state_d = MUL;
            end else begin
                case (state_q)
                    MUL: begin
                        if (am_done) begin
                            state_d = DONE;
                        end
                    end
                    DONE: begin
                        am_d    = am_prod[14:8];
                        pm_d    = pm_prod[14:7];
                        state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            lfsr_q  <= SEED;
            noise_q <= '0;
            state_q <= IDLE;
            am_q    <= '0;
            pm_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            lfsr_q  <= lfsr_d;
            noise_q <= noise_d;
            state_q <= state_d;
            am_q    <= am_d;
            pm_q    <= pm_d;
        end
    end

    assign am = am_q;
    assign pm = pm_q;

`ifdef JT51_LFO_PHASE_OUT_EN
    assign phase_o = phase;
`endif

endmodule

// File: tb/tb_jt51_lfo.sv
// Self-checking bench for jt51_lfo: arithmetic reference model plus literal checkpoints.
module tb_jt51_lfo;

    logic       clk = 1'b0;
    logic       rst, cen, zero, lfo_rst;
    logic [7:0] lfo_freq;
    logic [1:0] lfo_w;
    logic [6:0] lfo_amd, lfo_pmd;
    logic [6:0] am;
    logic [7:0] pm;
`ifdef JT51_LFO_PHASE_OUT_EN
    logic [7:0] phase_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    int m_acc, m_lfsr, m_noise, m_am, m_pm;
    bit pend_v;
    int pend_cnt, pend_am, pend_pm;

    always #5 clk = ~clk;

    jt51_lfo dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .zero     (zero),
        .lfo_rst  (lfo_rst),
        .lfo_freq (lfo_freq),
        .lfo_w    (lfo_w),
        .lfo_amd  (lfo_amd),
        .lfo_pmd  (lfo_pmd),
        .am       (am),
`ifdef JT51_LFO_PHASE_OUT_EN
        .pm       (pm),
        .phase_o  (phase_o)
`else
        .pm       (pm)
`endif
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference: outputs appear 8 cen-cycles after a tick; a new tick or lfo_rst cancels a pending result.
    task automatic model_edge(input bit r, input bit c, input bit z, input bit lr);
        int p, ua, sp, t, sum, step, amd_i, pmd_i;
        if (r) begin
            m_acc = 0; m_lfsr = 1; m_noise = 0; m_am = 0; m_pm = 0; pend_v = 0;
        end else if (c) begin
            if (lr) begin
                m_acc  = 0;
                pend_v = 0;
            end else if (z) begin
                p = m_acc / 4096;
                t = (p >= 128) ? 255 - 2 * (p - 128) : 2 * p;
                case (lfo_w)
                    2'd0:    begin ua = 255 - p; sp = p - 128; end
                    2'd1:    begin ua = (p >= 128) ? 0 : 255; sp = (p >= 128) ? -128 : 127; end
                    2'd2:    begin ua = t; sp = t - 128; end
                    default: begin ua = m_noise; sp = m_noise - 128; end
                endcase
                amd_i    = int'(lfo_amd);
                pmd_i    = int'(lfo_pmd);
                pend_am  = (ua * amd_i) / 256;
                pend_pm  = (sp * pmd_i) >>> 7;
                pend_v   = 1;
                pend_cnt = 8;
                step = (16 + int'(lfo_freq[3:0])) * (1 << int'(lfo_freq[7:4]));
                sum  = m_acc + step;
                if (sum >= (1 << 20)) begin
                    m_noise = m_lfsr % 256;
                    sum     = sum - (1 << 20);
                end
                m_acc  = sum;
                m_lfsr = ((m_lfsr * 2) % (1 << 17)) | (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1);
            end else if (pend_v) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    m_am   = pend_am;
                    m_pm   = pend_pm;
                    pend_v = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit z, input bit lr);
        rst     = r;
        cen     = c;
        zero    = z;
        lfo_rst = lr;
        @(posedge clk);
        model_edge(r, c, z, lr);
        #1;
    endtask

    task automatic tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sample();
        tick();
        idle(31);
    endtask

    // Hand-computed values pin both the DUT and the reference model.
    task automatic checkLit(input string name, input int exp_am, input int exp_pm);
        checkOutput($sformatf("%s_am", name), int'(am), exp_am);
        checkOutput($sformatf("%s_pm", name), int'($signed(pm)), exp_pm);
        checkOutput($sformatf("%s_model_am", name), m_am, exp_am);
        checkOutput($sformatf("%s_model_pm", name), m_pm, exp_pm);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("am_model", int'(am), m_am);
            checkOutput("pm_model", int'($signed(pm)), m_pm);
`ifdef JT51_LFO_PHASE_OUT_EN
            checkOutput("phase_model", int'(phase_o), m_acc / 4096);
`endif
        end
    end

    initial begin
        rst = 1'b1; cen = 1'b0; zero = 1'b0; lfo_rst = 1'b0;
        lfo_freq = '0; lfo_w = '0; lfo_amd = '0; lfo_pmd = '0;

        for (int i = 0; i < 3; i++) begin
            lfo_freq = 8'($urandom);
            lfo_w    = 2'($urandom);
            lfo_amd  = 7'($urandom);
            lfo_pmd  = 7'($urandom);
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            chk_en = 1'b1;
        end
        checkLit("reset", 0, 0);

        lfo_freq = 8'hF0; lfo_w = 2'd0; lfo_amd = 7'd127; lfo_pmd = 7'd127;
        tick(); idle(7);
        checkLit("saw_latency", 0, 0);
        idle(1);
        checkLit("saw_p00", 126, -127);
        idle(23);
        tick(); idle(8);
        checkLit("saw_p80", 63, 0);
        idle(23);

        lfo_w = 2'd1;
        tick(); idle(8);
        checkLit("sqr_p00", 126, 126);
        idle(23);
        tick(); idle(3);
        lfo_pmd = 7'd0;
        idle(5);
        checkLit("sqr_p80", 0, -127);
        idle(23);
        tick(); idle(8);
        checkLit("sqr_pmd0", 126, 0);
        idle(23);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        lfo_freq = 8'h00; lfo_w = 2'd2; lfo_amd = 7'd64; lfo_pmd = 7'd100;
        for (int i = 0; i < 2048; i++) tick();
        tick(); idle(8);
        checkLit("tri_p08", 4, -88);
        idle(23);
        lfo_amd = 7'd0; lfo_pmd = 7'd0;
        tick(); idle(8);
        checkLit("depth0", 0, 0);
        idle(23);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        lfo_freq = 8'hF0; lfo_w = 2'd3; lfo_amd = 7'd127; lfo_pmd = 7'd127;
        sample(); sample();
        tick(); idle(8);
        checkLit("noise_t3", 0, -126);
        idle(23);
        sample();
        tick(); idle(8);
        checkLit("noise_t5", 3, -120);
        idle(23);
        for (int i = 0; i < 40; i++) sample();

        lfo_w = 2'd0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        sample(); sample();
        tick(); idle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        idle(10);
        checkLit("lforst_hold", 63, 0);
        idle(17);
        tick(); idle(8);
        checkLit("lforst_release", 126, -127);
        idle(23);
        lfo_w = 2'd3;
        for (int i = 0; i < 10; i++) sample();

        // Gated cen: zero is raised only while cen is low, so it must be ignored.
        lfo_freq = 8'h93; lfo_amd = 7'd90; lfo_pmd = 7'd77;
        for (int s = 0; s < 8; s++) begin
            lfo_w = 2'(s);
            tick();
            for (int i = 1; i < 32; i++) begin
                applyStimulus(1'b0, 1'(i % 2), 1'((i % 4) == 0), 1'b0);
            end
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
